// File: rtl/sprite_addr_gen.sv
// Pipelined sprite-ROM address generator: maps the scan position relative to a sprite origin
// into a frame/orientation-aware ROM address with a fixed two-cycle latency.
module sprite_addr_gen #(
    parameter int SIZE     = 42,
    parameter int FRAMES   = 3,
    parameter int ADDR_W   = 13,
    parameter int PINGPONG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic [1:0]        dir,
    input  logic              anim_en,
    input  logic              frame_tick,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              in_sprite
);

    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam logic [FW-1:0] LAST_FRAME = FW'(FRAMES - 1);
    localparam logic [9:0]    SIZE_M1    = 10'(SIZE - 1);
    localparam logic [9:0]    SIZE_10    = 10'(SIZE);

    typedef enum logic {CNT_UP, CNT_DOWN} bounce_e;

    bounce_e             bounce_q, bounce_d;
    logic [FW-1:0]       frame_cnt_q, frame_cnt_d;
    logic [FW-1:0]       frame_q, frame_d;
    logic [1:0]          dir_q, dir_d;
    logic [9:0]          dx_q, dx_d, dy_q, dy_d;
    logic                inside_q, inside_d;
    logic [ADDR_W-1:0]   pixel_addr_q, pixel_addr_d;
    logic                in_sprite_q, in_sprite_d;
    logic [9:0]          col, row;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        bounce_d    = bounce_q;
        if (anim_en && frame_tick && (FRAMES > 1)) begin
            if (PINGPONG == 0) begin
                frame_cnt_d = (frame_cnt_q == LAST_FRAME) ? '0 : frame_cnt_q + FW'(1);
            end else if (bounce_q == CNT_UP) begin
                // Turn around on the endpoint so it is shown only once per pass.
                if (frame_cnt_q == LAST_FRAME) begin
                    frame_cnt_d = frame_cnt_q - FW'(1);
                    bounce_d    = CNT_DOWN;
                end else begin
                    frame_cnt_d = frame_cnt_q + FW'(1);
                end
            end else begin
                if (frame_cnt_q == '0) begin
                    frame_cnt_d = frame_cnt_q + FW'(1);
                    bounce_d    = CNT_UP;
                end else begin
                    frame_cnt_d = frame_cnt_q - FW'(1);
                end
            end
        end
    end

    // Orientation and frame change only at the top-left scan position to avoid tearing.
    always_comb begin
        dir_d   = dir_q;
        frame_d = frame_q;
        if (h_cnt == 10'd0 && v_cnt == 10'd0) begin
            dir_d   = dir;
            frame_d = frame_cnt_q;
        end
    end

    always_comb begin
        dx_d     = h_cnt - x;
        dy_d     = v_cnt - y;
        inside_d = (dx_d < SIZE_10) && (dy_d < SIZE_10);
    end

    always_comb begin
        col = dx_q;
        row = dy_q;
        case (dir_q)
            2'd1: col = SIZE_M1 - dx_q;
            2'd2: begin
                col = dy_q;
                row = SIZE_M1 - dx_q;
            end
            2'd3: begin
                col = SIZE_M1 - dy_q;
                row = dx_q;
            end
            default: ;
        endcase
        // Modular arithmetic at ADDR_W bits equals the full-width sum truncated to ADDR_W.
        pixel_addr_d = '0;
        if (inside_q) begin
            pixel_addr_d = ADDR_W'(frame_q) * ADDR_W'(SIZE * SIZE)
                         + ADDR_W'(row) * ADDR_W'(SIZE) + ADDR_W'(col);
        end
        in_sprite_d = inside_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q  <= '0;
            bounce_q     <= CNT_UP;
            dir_q        <= '0;
            frame_q      <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            inside_q     <= 1'b0;
            pixel_addr_q <= '0;
            in_sprite_q  <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            bounce_q     <= bounce_d;
            dir_q        <= dir_d;
            frame_q      <= frame_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            inside_q     <= inside_d;
            pixel_addr_q <= pixel_addr_d;
            in_sprite_q  <= in_sprite_d;
        end
    end

    assign pixel_addr = pixel_addr_q;
    assign in_sprite  = in_sprite_q;

endmodule
